// File: rtl/ascon_pack.sv
// ascon_pack: shared types for the data FIFO and its half-word packer.
package ascon_pack;
    typedef logic [63:0] u64_t;
    typedef enum logic {EMPTY_HALF = 1'b0, UPPER_HELD = 1'b1} pend_t;
endpackage

// File: rtl/data_fifo_word_packer.sv
// word_packer: assembles 32-bit bus writes into big-endian 64-bit entries.
module word_packer
    import ascon_pack::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_last_i,
    input  logic        full_i,
    output logic        commit_o,
    output u64_t        commit_data_o,
    output pend_t       pend_o
);
    logic [31:0] held_q, held_d;
    pend_t       pend_q, pend_d;
    logic        accept;

    // Writes arriving while the FIFO is full leave the holding state untouched.
    assign accept = wr_en_i & ~full_i & ~flush_i;
    assign pend_o = pend_q;

    always_comb begin
        held_d        = held_q;
        pend_d        = pend_q;
        commit_o      = 1'b0;
        commit_data_o = '0;
        if (flush_i) begin
            held_d = '0;
            pend_d = EMPTY_HALF;
        end else if (accept) begin
            if (pend_q == UPPER_HELD) begin
                commit_o      = 1'b1;
                commit_data_o = {held_q, wr_data_i};
                pend_d        = EMPTY_HALF;
            end else if (wr_last_i) begin
                commit_o      = 1'b1;
                commit_data_o = {wr_data_i, 32'h0};
            end else begin
                held_d = wr_data_i;
                pend_d = UPPER_HELD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
            pend_q <= EMPTY_HALF;
        end else begin
            held_q <= held_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/data_fifo.sv
// data_fifo: 64-bit first-word-fall-through FIFO fed by 32-bit bus writes,
// with sticky overflow/underflow flags and a synchronous flush.
module data_fifo
    import ascon_pack::*;
#(
    parameter int DEPTH_AW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [31:0]         wr_data_i,
    input  logic                wr_last_i,
    input  logic                pop_i,
    output u64_t                data_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [DEPTH_AW:0]   count_o,
    output logic                ovf_err_o,
    output logic                unf_err_o
);
    localparam int DEPTH = 1 << DEPTH_AW;

    u64_t                mem [DEPTH];
    logic [DEPTH_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_AW:0]   count_q, count_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                commit, pop_ok;
    u64_t                commit_data;
    pend_t               pend;

    word_packer u_pack (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .wr_last_i     (wr_last_i),
        .full_i        (full_o),
        .commit_o      (commit),
        .commit_data_o (commit_data),
        .pend_o        (pend)
    );

    assign empty_o   = count_q == '0;
    assign full_o    = count_q == (DEPTH_AW+1)'(DEPTH);
    assign count_o   = count_q;
    assign ovf_err_o = ovf_q;
    assign unf_err_o = unf_q;
    assign data_o    = empty_o ? '0 : mem[rd_ptr_q];
    assign pop_ok    = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (!flush_i) begin
            wr_ptr_d = wr_ptr_q + DEPTH_AW'(commit);
            rd_ptr_d = rd_ptr_q + DEPTH_AW'(pop_ok);
            count_d  = count_q + (DEPTH_AW+1)'(commit) - (DEPTH_AW+1)'(pop_ok);
            ovf_d    = ovf_q | (wr_en_i & full_o);
            unf_d    = unf_q | (pop_i & empty_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr_q] <= commit_data;
    end
endmodule
